// File: rtl/modn_counter_ctrl_pkg.sv
// modn_counter_ctrl_pkg: state type and helpers for the mod-N run controller
package modn_counter_ctrl_pkg;
`include "modn_ctrl_defs.vh"
  typedef enum logic [STATE_W-1:0] {
    IDLE  = ST_IDLE,
    RUN   = ST_RUN,
    PAUSE = ST_PAUSE,
    DONE  = ST_DONE
  } state_e;
endpackage

// File: rtl/modn_counter_ctrl_counter.sv
// modn_counter: mod-N up-counter datapath with enable and synchronous clear
module modn_counter #(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             tc_raw
);
  logic [WIDTH-1:0] count_q, count_d;
  always_comb begin
    tc_raw  = count_q == WIDTH'(MODULUS - 1);
    count_d = clr ? '0 : en ? (tc_raw ? '0 : count_q + WIDTH'(1)) : count_q;
  end
  always_ff @(posedge clock) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end
  assign count = count_q;
endmodule

// File: rtl/modn_ctrl_defs.vh
// modn_ctrl_defs: state encodings and state width shared by RTL and bench
`ifndef MODN_CTRL_DEFS_VH
`define MODN_CTRL_DEFS_VH
localparam int STATE_W = 2;
localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
localparam logic [STATE_W-1:0] ST_RUN   = 2'd1;
localparam logic [STATE_W-1:0] ST_PAUSE = 2'd2;
localparam logic [STATE_W-1:0] ST_DONE  = 2'd3;
`endif

// File: rtl/modn_counter_ctrl.sv
// modn_counter_ctrl: start/pause/abort run controller counting bursts of mod-N wraps
// Optional wraps output enabled by MODN_CTRL_WRAPS_EN.
module modn_counter_ctrl
  import modn_counter_ctrl_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 6,
  parameter int BURST_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               pause,
  input  logic               abort,
  input  logic [BURST_W-1:0] burst_len,
  output logic [WIDTH-1:0]   count,
  output logic               tc,
  output logic               busy,
  output logic               done,
`ifdef MODN_CTRL_WRAPS_EN
  output logic [BURST_W-1:0] wraps,
`endif
  output logic [STATE_W-1:0] state
);
  state_e             state_q, state_d;
  logic [BURST_W-1:0] remaining_q, remaining_d;
  logic               en, clr, tc_raw, accept, wrap, last;
  modn_counter #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u_cnt (
    .clock (clock),
    .reset (reset),
    .en    (en),
    .clr   (clr),
    .count (count),
    .tc_raw(tc_raw)
  );
  always_comb begin
    accept      = state_q == IDLE && !abort && !pause && start;
    en          = state_q == RUN && !abort && !pause;
    clr         = abort || !(state_q == RUN || state_q == PAUSE);
    wrap        = en && tc_raw;
    last        = remaining_q == BURST_W'(1);
    remaining_d = accept ? burst_len
                : (wrap && remaining_q > BURST_W'(1)) ? remaining_q - BURST_W'(1)
                : remaining_q;
    case (state_q)
      IDLE:    state_d = accept ? RUN : IDLE;
      RUN:     state_d = abort ? IDLE : pause ? PAUSE : (wrap && last) ? DONE : RUN;
      PAUSE:   state_d = abort ? IDLE : pause ? PAUSE : RUN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
    end
  end
`ifdef MODN_CTRL_WRAPS_EN
  logic [BURST_W-1:0] wraps_q, wraps_d;
  always_comb wraps_d = accept ? '0 : (wrap && wraps_q != '1) ? wraps_q + BURST_W'(1) : wraps_q;
  always_ff @(posedge clock) begin
    if (reset) wraps_q <= '0;
    else       wraps_q <= wraps_d;
  end
  assign wraps = wraps_q;
`endif
  assign state = state_q;
  assign tc    = state_q == RUN && tc_raw;
  assign busy  = state_q == RUN || state_q == PAUSE;
  assign done  = state_q == DONE;
endmodule

// File: tb/tb_modn_counter_ctrl.sv
// tb_modn_counter_ctrl: directed self-checking bench for modn_counter_ctrl (MODULUS=6, WIDTH=3)
module tb_modn_counter_ctrl;
  import modn_counter_ctrl_pkg::*;
  logic       clock = 0;
  logic       reset, start, pause, abort;
  logic [7:0] burst_len;
  logic [2:0] count;
  logic       tc, busy, done;
  logic [1:0] state;
`ifdef MODN_CTRL_WRAPS_EN
  logic [7:0] wraps;
`endif
  int errors = 0;
  int checks = 0;
  always #5 clock = ~clock;
  modn_counter_ctrl #(.WIDTH(3), .MODULUS(6), .BURST_W(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .pause    (pause),
    .abort    (abort),
    .burst_len(burst_len),
    .count    (count),
    .tc       (tc),
    .busy     (busy),
    .done     (done),
`ifdef MODN_CTRL_WRAPS_EN
    .wraps    (wraps),
`endif
    .state    (state)
  );
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic test_reset();
    reset = 1; start = 0; pause = 0; abort = 0; burst_len = 0;
    step(); step();
    reset = 0;
    checks++; if (state !== ST_IDLE || count !== 3'd0) begin errors++; $display("FAIL reset_init state=%0d count=%0d want 0/0", state, count); end
    start = 1; step(); start = 0;
    step(); step(); step();
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL reset_precount count=%0d want 3", count); end
    reset = 1; step();
    checks++; if (state !== ST_IDLE || count !== 3'd0) begin errors++; $display("FAIL reset_mid1 state=%0d count=%0d want 0/0", state, count); end
    step(); reset = 0;
    checks++; if ({state, count, busy, done, tc} !== 7'd0) begin errors++; $display("FAIL reset_mid2 state=%0d count=%0d busy=%0d done=%0d tc=%0d want all 0", state, count, busy, done, tc); end
    step();
    checks++; if (state !== ST_IDLE || count !== 3'd0) begin errors++; $display("FAIL reset_idle_hold state=%0d count=%0d want 0/0", state, count); end
  endtask
  task automatic test_burst();
    burst_len = 8'd2; start = 1; step(); start = 0; burst_len = 8'd7;
    for (int k = 0; k < 12; k++) begin
      checks++; if (state !== ST_RUN || count !== 3'(k % 6) || tc !== (k % 6 == 5) || busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL burst_k%0d state=%0d count=%0d tc=%0d busy=%0d done=%0d want 1/%0d/%0d/1/0", k, state, count, tc, busy, done, k % 6, k % 6 == 5); end
      step();
    end
    checks++; if (state !== ST_DONE || done !== 1'b1 || count !== 3'd0 || busy !== 1'b0 || tc !== 1'b0) begin errors++; $display("FAIL burst_done state=%0d done=%0d count=%0d busy=%0d want 3/1/0/0", state, done, count, busy); end
`ifdef MODN_CTRL_WRAPS_EN
    checks++; if (wraps !== 8'd2) begin errors++; $display("FAIL burst_wraps wraps=%0d want 2", wraps); end
`endif
    step();
    checks++; if (state !== ST_IDLE || done !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL burst_idle state=%0d done=%0d count=%0d want 0/0/0", state, done, count); end
`ifdef MODN_CTRL_WRAPS_EN
    checks++; if (wraps !== 8'd2) begin errors++; $display("FAIL burst_wraps_idle wraps=%0d want 2", wraps); end
`endif
  endtask
  task automatic test_pause();
    burst_len = 8'd0; start = 1; step(); start = 0;
    step(); step(); step();
    pause = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (state !== ST_PAUSE || count !== 3'd3 || tc !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL pause_hold%0d state=%0d count=%0d tc=%0d busy=%0d want 2/3/0/1", k, state, count, tc, busy); end
    end
    pause = 0; step();
    checks++; if (state !== ST_RUN || count !== 3'd3) begin errors++; $display("FAIL pause_release state=%0d count=%0d want 1/3", state, count); end
    step();
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL pause_resume4 count=%0d want 4", count); end
    step();
    checks++; if (count !== 3'd5 || tc !== 1'b1) begin errors++; $display("FAIL pause_resume5 count=%0d tc=%0d want 5/1", count, tc); end
    pause = 1; step();
    checks++; if (state !== ST_PAUSE || count !== 3'd5 || tc !== 1'b0) begin errors++; $display("FAIL pause_at_tc state=%0d count=%0d tc=%0d want 2/5/0", state, count, tc); end
    pause = 0; step();
    checks++; if (state !== ST_RUN || count !== 3'd5 || tc !== 1'b1) begin errors++; $display("FAIL pause_tc_back state=%0d count=%0d tc=%0d want 1/5/1", state, count, tc); end
    step();
    checks++; if (count !== 3'd0 || tc !== 1'b0) begin errors++; $display("FAIL pause_wrap count=%0d tc=%0d want 0/0", count, tc); end
    abort = 1; step(); abort = 0;
    checks++; if (state !== ST_IDLE || count !== 3'd0) begin errors++; $display("FAIL pause_abort state=%0d count=%0d want 0/0", state, count); end
  endtask
  task automatic test_abort();
    int seen;
    seen = 0;
    burst_len = 8'd3; start = 1; step(); start = 0;
    step(); step(); step(); step();
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL abort_pre count=%0d want 4", count); end
    abort = 1; step(); abort = 0;
    checks++; if (state !== ST_IDLE || count !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_now state=%0d count=%0d busy=%0d done=%0d want 0/0/0/0", state, count, busy, done); end
    for (int k = 0; k < 20; k++) begin
      if (done || state !== ST_IDLE) seen++;
      step();
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_quiet bad_cycles=%0d want 0", seen); end
    abort = 1; start = 1; step(); abort = 0; start = 0;
    checks++; if (state !== ST_IDLE || count !== 3'd0) begin errors++; $display("FAIL abort_start_idle state=%0d count=%0d want 0/0", state, count); end
  endtask
  task automatic test_freerun();
    int ntc, ndone, last_tc, bad_gap;
    ntc = 0; ndone = 0; last_tc = -1; bad_gap = 0;
    burst_len = 8'd0; start = 1; step(); start = 0;
    for (int k = 0; k < 40; k++) begin
      if (tc) begin
        if (last_tc >= 0 && k - last_tc != 6) bad_gap++;
        if (last_tc < 0 && k != 5) bad_gap++;
        last_tc = k; ntc++;
      end
      if (done || state !== ST_RUN) ndone++;
      step();
    end
    checks++; if (ntc !== 6) begin errors++; $display("FAIL freerun_tc_count got=%0d want 6", ntc); end
    checks++; if (bad_gap !== 0) begin errors++; $display("FAIL freerun_tc_period bad=%0d want 0", bad_gap); end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL freerun_no_done bad=%0d want 0", ndone); end
`ifdef MODN_CTRL_WRAPS_EN
    checks++; if (wraps !== 8'd6) begin errors++; $display("FAIL freerun_wraps wraps=%0d want 6", wraps); end
`endif
    abort = 1; step(); abort = 0;
    checks++; if (state !== ST_IDLE || done !== 1'b0) begin errors++; $display("FAIL freerun_abort state=%0d done=%0d want 0/0", state, done); end
  endtask
  task automatic test_back_to_back();
    burst_len = 8'd2; start = 1; step(); start = 0;
`ifdef MODN_CTRL_WRAPS_EN
    checks++; if (wraps !== 8'd0) begin errors++; $display("FAIL b2b_wraps_clear wraps=%0d want 0", wraps); end
`endif
    for (int k = 0; k < 12; k++) begin
      checks++; if (state !== ST_RUN || count !== 3'(k % 6)) begin errors++; $display("FAIL b2b_k%0d state=%0d count=%0d want 1/%0d", k, state, count, k % 6); end
      start = (k == 2 || k == 7); burst_len = 8'd1;
      step();
    end
    start = 0;
    checks++; if (state !== ST_DONE || done !== 1'b1) begin errors++; $display("FAIL b2b_done state=%0d done=%0d want 3/1", state, done); end
    start = 1; step(); start = 0;
    checks++; if (state !== ST_IDLE || count !== 3'd0) begin errors++; $display("FAIL b2b_start_in_done state=%0d count=%0d want 0/0", state, count); end
`ifdef MODN_CTRL_WRAPS_EN
    checks++; if (wraps !== 8'd2) begin errors++; $display("FAIL b2b_wraps_hold wraps=%0d want 2", wraps); end
`endif
    burst_len = 8'd1; start = 1; step(); start = 0;
`ifdef MODN_CTRL_WRAPS_EN
    checks++; if (wraps !== 8'd0) begin errors++; $display("FAIL b2b_wraps_restart wraps=%0d want 0", wraps); end
`endif
    for (int k = 0; k < 6; k++) step();
    checks++; if (state !== ST_DONE || done !== 1'b1 || count !== 3'd0) begin errors++; $display("FAIL b2b_single state=%0d done=%0d count=%0d want 3/1/0", state, done, count); end
    step();
    checks++; if (state !== ST_IDLE || done !== 1'b0) begin errors++; $display("FAIL b2b_single_idle state=%0d done=%0d want 0/0", state, done); end
  endtask
  initial begin
    test_reset();
    test_burst();
    test_pause();
    test_abort();
    test_freerun();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
